// File: rtl/fright_pkg.sv
// Shared types and constants for the frightened-mode controller.
// Pure declarations; no latency or flow-control behaviour of its own.
package fright_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRIGHT = 2'd1,
        ST_FLASH  = 2'd2
    } fright_state_e;

    localparam logic [1:0]  PAL_NORMAL = 2'd0;
    localparam logic [1:0]  PAL_BLUE   = 2'd1;
    localparam logic [1:0]  PAL_WHITE  = 2'd2;
    localparam logic [11:0] BASE_AWARD = 12'd200;

    // Palette for a frightened ghost; unfrightened ghosts are masked by the caller.
    function automatic logic [1:0] pal_code(fright_state_e st, logic [1:0] phase);
        case (st)
            ST_FRIGHT: return PAL_BLUE;
            ST_FLASH:  return phase;
            default:   return PAL_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/fright_mode_ctrl_if.sv
// Frame/pellet/eat pulses in, per-ghost fright state and score awards out.
// Pulse-based: no valid/ready, every signal is sampled each cycle.
interface fright_mode_ctrl_if;
    logic        frame_tick;
    logic        power_pellet;
    logic [3:0]  ghost_eaten;
    logic [3:0]  frightened;
    logic [7:0]  ghost_pal_sel;
    logic        fright_active;
    logic        score_valid;
    logic [11:0] score_award;

    modport master (
        output frame_tick, power_pellet, ghost_eaten,
        input  frightened, ghost_pal_sel, fright_active, score_valid, score_award
    );

    modport slave (
        input  frame_tick, power_pellet, ghost_eaten,
        output frightened, ghost_pal_sel, fright_active, score_valid, score_award
    );
endinterface

// File: rtl/ghost_award_q.sv
// Queues eaten ghosts and issues one escalating award per cycle, lowest index first.
// 1-cycle latency from eat to award; no backpressure, the queue drains one entry per cycle.
module ghost_award_q
    import fright_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  eat_hit,
    input  logic        combo_clr,
    output logic        score_valid,
    output logic [11:0] score_award
);

    logic [3:0] pending;
    logic [3:0] pend_all;
    logic [3:0] grant;
    logic [1:0] combo;

    // New eats join the queue in the same cycle so the first award lands one cycle later.
    always_comb begin
        pend_all = pending | eat_hit;
        grant    = pend_all & (~pend_all + 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            combo       <= '0;
            score_valid <= 1'b0;
            score_award <= '0;
        end else begin
            pending     <= pend_all & ~grant;
            score_valid <= |pend_all;
            score_award <= (|pend_all) ? (BASE_AWARD << combo) : 12'd0;
            if (combo_clr)
                combo <= '0;
            else if ((|pend_all) && (combo != 2'd3))
                combo <= combo + 2'd1;
        end
    end

endmodule

// File: rtl/fright_mode_ctrl.sv
// Frightened/flashing ghost mode sequencer with eat detection and award queue.
// All outputs registered, 1-cycle latency; no backpressure, pulses are consumed every cycle.
module fright_mode_ctrl
    import fright_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120,
    parameter int FLASH_PERIOD  = 12
) (
    input  logic               clk,
    input  logic               rst,
    fright_mode_ctrl_if.slave  bus
);

    localparam logic [9:0] FRIGHT_CNT  = 10'(FRIGHT_FRAMES);
    localparam logic [9:0] FLASH_ENTRY = 10'(FLASH_FRAMES + 1);
    localparam logic [9:0] PERIOD_LAST = 10'(FLASH_PERIOD - 1);

    fright_state_e state, state_n;
    logic [9:0]    cnt, cnt_n;
    logic [9:0]    fc, fc_n;
    logic [1:0]    phase, phase_n;
    logic [3:0]    fr_q, fr_n, eat_hit;
    logic [7:0]    pal_q, pal_n;
    logic          act_q;

    always_comb begin
        eat_hit = bus.ghost_eaten & fr_q;
        state_n = state;
        cnt_n   = cnt;
        fc_n    = fc;
        phase_n = phase;
        fr_n    = fr_q & ~eat_hit;
        // A pellet overrides everything, including a coincident frame tick.
        if (bus.power_pellet) begin
            state_n = ST_FRIGHT;
            cnt_n   = FRIGHT_CNT;
            fr_n    = 4'hF & ~eat_hit;
            phase_n = PAL_BLUE;
            fc_n    = '0;
        end else if (state != ST_IDLE) begin
            if (fr_n == 4'h0) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end else if (bus.frame_tick) begin
                cnt_n = cnt - 10'd1;
                if (state == ST_FRIGHT) begin
                    if (cnt == FLASH_ENTRY) begin
                        state_n = ST_FLASH;
                        phase_n = PAL_BLUE;
                        fc_n    = '0;
                    end
                end else if (cnt == 10'd1) begin
                    state_n = ST_IDLE;
                    fr_n    = '0;
                end else if (fc == PERIOD_LAST) begin
                    fc_n    = '0;
                    phase_n = (phase == PAL_BLUE) ? PAL_WHITE : PAL_BLUE;
                end else begin
                    fc_n = fc + 10'd1;
                end
            end
        end
        for (int i = 0; i < 4; i++)
            pal_n[2*i +: 2] = fr_n[i] ? pal_code(state_n, phase_n) : PAL_NORMAL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            fc    <= '0;
            phase <= PAL_BLUE;
            fr_q  <= '0;
            pal_q <= '0;
            act_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            fc    <= fc_n;
            phase <= phase_n;
            fr_q  <= fr_n;
            pal_q <= pal_n;
            act_q <= (state_n != ST_IDLE);
        end
    end

    assign bus.frightened    = fr_q;
    assign bus.ghost_pal_sel = pal_q;
    assign bus.fright_active = act_q;

    ghost_award_q u_award (
        .clk         (clk),
        .rst         (rst),
        .eat_hit     (eat_hit),
        .combo_clr   (bus.power_pellet),
        .score_valid (bus.score_valid),
        .score_award (bus.score_award)
    );

endmodule
